// File: rtl/fpr_wb_scheduler.sv
// FP register scoreboard and round-robin write-back arbiter.
// Issue stalls on RAW/WAW hazards; one FPU result is written back per cycle.
module fpr_wb_scheduler #(
    parameter int NUM_UNITS = 3,
    parameter int DW        = 32,
    parameter int UW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_rs1,
    input  logic [4:0]             issue_rs2,
    input  logic                   issue_use_rs2,
    input  logic [4:0]             issue_rd,
    input  logic [UW-1:0]          issue_unit,
    input  logic [NUM_UNITS-1:0]   unit_free,
    output logic                   issue_ready,
    input  logic [NUM_UNITS-1:0]   res_valid,
    input  logic [5*NUM_UNITS-1:0] res_rd,
    input  logic [DW*NUM_UNITS-1:0] res_data,
    output logic [NUM_UNITS-1:0]   res_ready,
    output logic                   reg_write,
    output logic [4:0]             rdi,
    output logic [DW-1:0]          write_data,
    output logic [31:0]            busy,
    output logic                   sb_err
);

    logic [4:0]    rd_arr   [NUM_UNITS];
    logic [DW-1:0] data_arr [NUM_UNITS];

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unpack
        assign rd_arr[i]   = res_rd[5*i +: 5];
        assign data_arr[i] = res_data[DW*i +: DW];
    end

    logic [UW-1:0] rr;
    logic [UW-1:0] gidx;
    logic [UW-1:0] cand;
    logic          found;
    logic          unit_ok;
    logic [4:0]    g_rd;
    logic [31:0]   busy_next;

    // Out-of-range unit indices never match, so they are never ready.
    always_comb begin
        unit_ok = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (issue_unit == UW'(i)) unit_ok = unit_free[i];
        end
        issue_ready = !busy[issue_rs1]
                    & !(issue_use_rs2 & busy[issue_rs2])
                    & !busy[issue_rd]
                    & unit_ok;
    end

    // Search starts just after the last granted unit.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_UNITS; k++) begin
            cand = UW'((int'(rr) + k) % NUM_UNITS);
            if (!found && res_valid[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        res_ready = found ? (NUM_UNITS'(1) << gidx) : '0;
        g_rd      = rd_arr[gidx];
    end

    // Set is applied after clear so a same-edge collision keeps the bit set.
    always_comb begin
        busy_next = busy;
        if (found) busy_next[g_rd] = 1'b0;
        if (issue_valid && issue_ready) busy_next[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            reg_write  <= 1'b0;
            rdi        <= '0;
            write_data <= '0;
            sb_err     <= 1'b0;
            rr         <= UW'(NUM_UNITS - 1);
        end else begin
            busy      <= busy_next;
            reg_write <= found;
            if (found) begin
                rdi        <= g_rd;
                write_data <= data_arr[gidx];
                rr         <= gidx;
                if (!busy[g_rd]) sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpr_wb_scheduler.sv
// Directed bench for fpr_wb_scheduler: issue hazards, arbitration,
// write-back timing and scoreboard error flag.
module tb_fpr_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use_rs2;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_unit;
    logic [2:0]  unit_free;
    logic        issue_ready;
    logic [2:0]  res_valid;
    logic [14:0] res_rd;
    logic [95:0] res_data;
    logic [2:0]  res_ready;
    logic        reg_write;
    logic [4:0]  rdi;
    logic [31:0] write_data;
    logic [31:0] busy;
    logic        sb_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpr_wb_scheduler #(.NUM_UNITS(3), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_use_rs2(issue_use_rs2),
        .issue_rd(issue_rd), .issue_unit(issue_unit),
        .unit_free(unit_free), .issue_ready(issue_ready),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
        .res_ready(res_ready), .reg_write(reg_write), .rdi(rdi),
        .write_data(write_data), .busy(busy), .sb_err(sb_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_use_rs2 = 0;
        issue_rd = 0; issue_unit = 0; unit_free = 3'b111;
        res_valid = 0; res_rd = 0; res_data = 0;
        do_reset();
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want %h", busy, 32'h0); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b want 0", reg_write); end
        checks++; if (rdi !== 5'd0) begin errors++; $display("FAIL reset_rdi: got %0d want 0", rdi); end
        checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", write_data); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %b want 0", sb_err); end
        checks++; if (res_ready !== 3'b000) begin errors++; $display("FAIL reset_res_ready: got %b want 000", res_ready); end
    endtask

    task automatic test_issue();
        issue_valid = 1; issue_rd = 5; issue_rs1 = 0; issue_unit = 0;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL issue_rd5_ready: got %b want 1", issue_ready); end
        tick();
        issue_valid = 0;
        checks++; if (busy !== 32'h0000_0020) begin errors++; $display("FAIL issue_busy5: got %h want %h", busy, 32'h20); end
        issue_rs1 = 5; issue_rd = 6;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL issue_raw_rs1: got %b want 0", issue_ready); end
    endtask

    task automatic test_writeback();
        res_valid = 3'b001; res_rd = {5'd0, 5'd0, 5'd5};
        res_data = {32'h0, 32'h0, 32'h3F80_0000};
        #1;
        checks++; if (res_ready !== 3'b001) begin errors++; $display("FAIL wb_grant: got %b want 001", res_ready); end
        tick();
        res_valid = 0;
        #1;
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL wb_reg_write: got %b want 1", reg_write); end
        checks++; if (rdi !== 5'd5) begin errors++; $display("FAIL wb_rdi: got %0d want 5", rdi); end
        checks++; if (write_data !== 32'h3F80_0000) begin errors++; $display("FAIL wb_wdata: got %h want 3f800000", write_data); end
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL wb_busy_clear: got %h want 0", busy); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL wb_dep_issue: got %b want 1", issue_ready); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL wb_sb_err: got %b want 0", sb_err); end
        tick();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL wb_idle_we: got %b want 0", reg_write); end
        checks++; if (rdi !== 5'd5) begin errors++; $display("FAIL wb_idle_rdi_hold: got %0d want 5", rdi); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [4];
        logic [4:0] exp_rd [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        exp_rd[0] = 5'd10; exp_rd[1] = 5'd11; exp_rd[2] = 5'd12; exp_rd[3] = 5'd10;
        do_reset();
        res_valid = 3'b111; res_rd = {5'd12, 5'd11, 5'd10};
        res_data = {32'hCCCC_0000, 32'hBBBB_0000, 32'hAAAA_0000};
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (res_ready !== exp_g[c]) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", c, res_ready, exp_g[c]); end
            tick();
            checks++; if (rdi !== exp_rd[c]) begin errors++; $display("FAIL rr_rdi_%0d: got %0d want %0d", c, rdi, exp_rd[c]); end
        end
        res_valid = 0;
        checks++; if (write_data !== 32'hAAAA_0000) begin errors++; $display("FAIL rr_wdata: got %h want aaaa0000", write_data); end
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL rr_sb_err: got %b want 1", sb_err); end
        do_reset();
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rr_sb_err_reset: got %b want 0", sb_err); end
    endtask

    task automatic test_waw();
        issue_valid = 1; issue_rd = 7; issue_rs1 = 0; issue_rs2 = 0;
        issue_use_rs2 = 0; issue_unit = 0;
        tick();
        issue_valid = 0;
        checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL waw_busy7: got %h want 80", busy); end
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_rd7: got %b want 0", issue_ready); end
        issue_rd = 8; issue_rs2 = 7; issue_use_rs2 = 0;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_rs2_ignored: got %b want 1", issue_ready); end
        issue_use_rs2 = 1;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_rs2_used: got %b want 0", issue_ready); end
        issue_use_rs2 = 0; issue_rs2 = 0;
    endtask

    task automatic test_unit_free();
        issue_rd = 20; issue_unit = 1; unit_free = 3'b101;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL unit1_busy: got %b want 0", issue_ready); end
        unit_free = 3'b111;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL unit1_free: got %b want 1", issue_ready); end
        issue_unit = 3;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL unit_out_of_range: got %b want 0", issue_ready); end
        issue_unit = 0;
    endtask

    task automatic test_sb_err();
        res_valid = 3'b100; res_rd = {5'd9, 5'd0, 5'd0};
        res_data = {32'h1234_5678, 64'h0};
        #1;
        checks++; if (res_ready !== 3'b100) begin errors++; $display("FAIL sberr_grant: got %b want 100", res_ready); end
        tick();
        res_valid = 3'b001; res_rd = {5'd0, 5'd0, 5'd7};
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sberr_set: got %b want 1", sb_err); end
        checks++; if (reg_write !== 1'b1 || rdi !== 5'd9) begin errors++; $display("FAIL sberr_write: got we=%b rdi=%0d want we=1 rdi=9", reg_write, rdi); end
        tick();
        res_valid = 0;
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL sberr_busy7_clear: got %h want 0", busy); end
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sberr_sticky: got %b want 1", sb_err); end
        issue_valid = 1;
        for (int r = 0; r < 32; r++) begin
            issue_rd = 5'(r); issue_rs1 = 5'(r); issue_rs2 = 5'(r);
            tick();
        end
        issue_valid = 0;
        checks++; if (busy !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sberr_busy_full: got %h want ffffffff", busy); end
        do_reset();
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL sberr_reset_busy: got %h want 0", busy); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sberr_reset_flag: got %b want 0", sb_err); end
    endtask

    initial begin
        rst = 1'b1;
        #2;
        test_reset();
        test_issue();
        test_writeback();
        test_round_robin();
        test_waw();
        test_unit_free();
        test_sb_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
